// File: rtl/adbg_halt_pkg.sv
// Shared types for the multi-core halt/resume/step controller.
package adbg_halt_pkg;

    localparam int unsigned CMD_W   = 2;
    localparam int unsigned CAUSE_W = 2;
    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_STEP = 2'd2
    } halt_state_e;

    typedef enum logic [CAUSE_W-1:0] {
        CAUSE_NONE  = 2'd0,
        CAUSE_BP    = 2'd1,
        CAUSE_HOST  = 2'd2,
        CAUSE_GROUP = 2'd3
    } halt_cause_e;

    typedef enum logic [CMD_W-1:0] {
        CMD_HALT   = 2'd0,
        CMD_RESUME = 2'd1,
        CMD_STEP   = 2'd2,
        CMD_CLEAR  = 2'd3
    } halt_cmd_e;

endpackage

// File: rtl/adbg_halt_core_fsm.sv
// Per-core run/halt/step state machine with sticky cause and event flag.
module adbg_halt_core_fsm
    import adbg_halt_pkg::*;
(
    input  logic        cpu_clk_i,
    input  logic        cpu_rstn_i,
    input  logic        cmd_halt,
    input  logic        cmd_resume,
    input  logic        cmd_step,
    input  logic        cmd_clear,
    input  logic        bp,
    input  logic        retire,
    input  logic        grp_trig,
    output halt_state_e state,
    output halt_cause_e cause,
    output logic        evt,
    output logic        bp_take_c
);

    halt_state_e state_d;
    halt_cause_e cause_d;
    logic        evt_d;

    // Next-state, cause and event; a halt entry overrides a same-cycle CLEAR.
    always_comb begin
        state_d   = state;
        cause_d   = cause;
        evt_d     = evt;
        bp_take_c = 1'b0;

        if (cmd_clear) begin
            cause_d = CAUSE_NONE;
            evt_d   = 1'b0;
        end

        case (state)
            ST_RUN, ST_STEP: begin
                if (bp) begin
                    state_d   = ST_HALT;
                    cause_d   = CAUSE_BP;
                    evt_d     = 1'b1;
                    bp_take_c = 1'b1;
                end else if (cmd_halt) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_HOST;
                    evt_d   = 1'b1;
                end else if (grp_trig) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_GROUP;
                    evt_d   = 1'b1;
                end else if ((state == ST_STEP) && retire) begin
                    // Step completion is reported as a host halt.
                    state_d = ST_HALT;
                    cause_d = CAUSE_HOST;
                    evt_d   = 1'b1;
                end
            end
            ST_HALT: begin
                if (bp) begin
                    cause_d = CAUSE_BP;
                end else if (cmd_resume) begin
                    state_d = ST_RUN;
                end else if (cmd_step) begin
                    state_d = ST_STEP;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State, cause and event registers.
    always_ff @(posedge cpu_clk_i or negedge cpu_rstn_i) begin
        if (!cpu_rstn_i) begin
            state <= ST_RUN;
            cause <= CAUSE_NONE;
            evt   <= 1'b0;
        end else begin
            state <= state_d;
            cause <= cause_d;
            evt   <= evt_d;
        end
    end

endmodule

// File: rtl/adbg_mc_halt_ctrl.sv
// Multi-core halt controller: per-core FSMs, group cross-trigger and command ack.
module adbg_mc_halt_ctrl
    import adbg_halt_pkg::*;
#(
    parameter int unsigned NB_CORES  = 4,
    parameter int unsigned NB_GROUPS = 2
) (
    input  logic                                 cpu_clk_i,
    input  logic                                 cpu_rstn_i,
    input  logic                                 cmd_valid_i,
    input  logic [CMD_W-1:0]                     cmd_i,
    input  logic [NB_CORES-1:0]                  cmd_mask_i,
    output logic                                 cmd_ack_o,
    input  logic                                 xtrig_en_i,
    input  logic [NB_GROUPS-1:0][NB_CORES-1:0]   grp_mask_i,
    input  logic [NB_CORES-1:0]                  bp_i,
    input  logic [NB_CORES-1:0]                  retire_i,
    output logic [NB_CORES-1:0]                  cpu_stall_o,
    output logic [NB_CORES-1:0]                  halted_o,
    output logic [CAUSE_W*NB_CORES-1:0]          cause_o,
    output logic [NB_CORES-1:0]                  event_o
);

    halt_cmd_e           cmd_e;
    logic                cmd_halt_c;
    logic                cmd_resume_c;
    logic                cmd_step_c;
    logic                cmd_clear_c;
    logic [NB_CORES-1:0] bp_take_c;
    logic [NB_CORES-1:0] grp_trig_c;

    assign cmd_e        = halt_cmd_e'(cmd_i);
    assign cmd_halt_c   = cmd_valid_i && (cmd_e == CMD_HALT);
    assign cmd_resume_c = cmd_valid_i && (cmd_e == CMD_RESUME);
    assign cmd_step_c   = cmd_valid_i && (cmd_e == CMD_STEP);
    assign cmd_clear_c  = cmd_valid_i && (cmd_e == CMD_CLEAR);

    // Cross-trigger: a core halts if another member of a shared group takes a breakpoint.
    always_comb begin
        grp_trig_c = '0;
        for (int g = 0; g < int'(NB_GROUPS); g++) begin
            for (int i = 0; i < int'(NB_CORES); i++) begin
                if (grp_mask_i[g][i] &&
                    (|(grp_mask_i[g] & bp_take_c & ~(NB_CORES'(1) << i)))) begin
                    grp_trig_c[i] = 1'b1;
                end
            end
        end
        if (!xtrig_en_i) begin
            grp_trig_c = '0;
        end
    end

    // One FSM per core; stall combines the held HALT state with a live breakpoint.
    for (genvar i = 0; i < int'(NB_CORES); i++) begin : g_core
        halt_state_e core_state;
        halt_cause_e core_cause;

        adbg_halt_core_fsm u_fsm (
            .cpu_clk_i  (cpu_clk_i),
            .cpu_rstn_i (cpu_rstn_i),
            .cmd_halt   (cmd_halt_c   & cmd_mask_i[i]),
            .cmd_resume (cmd_resume_c & cmd_mask_i[i]),
            .cmd_step   (cmd_step_c   & cmd_mask_i[i]),
            .cmd_clear  (cmd_clear_c  & cmd_mask_i[i]),
            .bp         (bp_i[i]),
            .retire     (retire_i[i]),
            .grp_trig   (grp_trig_c[i]),
            .state      (core_state),
            .cause      (core_cause),
            .evt        (event_o[i]),
            .bp_take_c  (bp_take_c[i])
        );

        assign halted_o[i]                    = (core_state == ST_HALT);
        assign cpu_stall_o[i]                 = (core_state == ST_HALT) | bp_i[i];
        assign cause_o[CAUSE_W*i +: CAUSE_W]  = core_cause;
    end

    // Every command strobe is acknowledged exactly one cycle later.
    always_ff @(posedge cpu_clk_i or negedge cpu_rstn_i) begin
        if (!cpu_rstn_i) begin
            cmd_ack_o <= 1'b0;
        end else begin
            cmd_ack_o <= cmd_valid_i;
        end
    end

endmodule

// File: tb/tb_adbg_mc_halt_ctrl.sv
// Directed, table-driven bench for the multi-core halt controller.
module tb_adbg_mc_halt_ctrl;

    localparam int NC = 4;
    localparam int NG = 2;

    localparam logic [1:0] C_HALT   = 2'd0;
    localparam logic [1:0] C_RESUME = 2'd1;
    localparam logic [1:0] C_STEP   = 2'd2;
    localparam logic [1:0] C_CLEAR  = 2'd3;

    logic                      clk;
    logic                      rst_n;
    logic                      cmd_valid;
    logic [1:0]                cmd;
    logic [NC-1:0]             cmd_mask;
    logic                      cmd_ack;
    logic                      xtrig_en;
    logic [NG-1:0][NC-1:0]     grp_mask;
    logic [NC-1:0]             bp;
    logic [NC-1:0]             retire;
    logic [NC-1:0]             stall;
    logic [NC-1:0]             halted;
    logic [2*NC-1:0]           cause;
    logic [NC-1:0]             evt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          v;
        logic [1:0]    cmd;
        logic [NC-1:0] mask;
        logic          xen;
        logic [NC-1:0] bp;
        logic [NC-1:0] ret;
        logic [NC-1:0] e_stall;   // stall before the edge
        logic [NC-1:0] e_halt;    // after the edge
        logic [7:0]    e_cause;
        logic [NC-1:0] e_evt;
        logic          e_ack;
    } vec_t;

    vec_t vecs[22];

    adbg_mc_halt_ctrl #(.NB_CORES(NC), .NB_GROUPS(NG)) dut (
        .cpu_clk_i   (clk),
        .cpu_rstn_i  (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_i       (cmd),
        .cmd_mask_i  (cmd_mask),
        .cmd_ack_o   (cmd_ack),
        .xtrig_en_i  (xtrig_en),
        .grp_mask_i  (grp_mask),
        .bp_i        (bp),
        .retire_i    (retire),
        .cpu_stall_o (stall),
        .halted_o    (halted),
        .cause_o     (cause),
        .event_o     (evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic v, input logic [1:0] c, input logic [3:0] m,
                                input logic x, input logic [3:0] b, input logic [3:0] r,
                                input logic [3:0] es, input logic [3:0] eh,
                                input logic [7:0] ec, input logic [3:0] ee, input logic ea);
        vec_t t;
        t.v = v; t.cmd = c; t.mask = m; t.xen = x; t.bp = b; t.ret = r;
        t.e_stall = es; t.e_halt = eh; t.e_cause = ec; t.e_evt = ee; t.e_ack = ea;
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, got, exp);
        end
    endtask

    // Drive one vector at the falling edge, check stall, then registered outputs after the rising edge.
    task automatic apply(input vec_t t, input int idx);
        @(negedge clk);
        cmd_valid = t.v; cmd = t.cmd; cmd_mask = t.mask;
        xtrig_en = t.xen; bp = t.bp; retire = t.ret;
        #1;
        chk("stall_pre", idx, 32'(stall), 32'(t.e_stall));
        @(posedge clk);
        #1;
        chk("halted", idx, 32'(halted), 32'(t.e_halt));
        chk("cause",  idx, 32'(cause),  32'(t.e_cause));
        chk("event",  idx, 32'(evt),    32'(t.e_evt));
        chk("ack",    idx, 32'(cmd_ack), 32'(t.e_ack));
        chk("stall_post", idx, 32'(stall), 32'(t.e_halt | t.bp));
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_stall"},  0, 32'(stall),   32'd0);
        chk({name, "_halted"}, 0, 32'(halted),  32'd0);
        chk({name, "_cause"},  0, 32'(cause),   32'd0);
        chk({name, "_event"},  0, 32'(evt),     32'd0);
        chk({name, "_ack"},    0, 32'(cmd_ack), 32'd0);
    endtask

    initial begin
        //            v  cmd       mask     x  bp       ret      stall    halt     cause         evt      ack
        vecs[0]  = mk(0, C_HALT,   4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'b00000000, 4'b0000, 0);
        vecs[1]  = mk(1, C_HALT,   4'b0101, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0101, 8'b00100010, 4'b0101, 1);
        vecs[2]  = mk(1, C_RESUME, 4'b0001, 0, 4'b0000, 4'b0000, 4'b0101, 4'b0100, 8'b00100010, 4'b0101, 1);
        vecs[3]  = mk(1, C_RESUME, 4'b0100, 0, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 8'b00100010, 4'b0101, 1);
        vecs[4]  = mk(1, C_CLEAR,  4'b1111, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'b00000000, 4'b0000, 1);
        // group 0 = {0,1,2}: breakpoint on core 0 cross-triggers 1 and 2
        vecs[5]  = mk(0, C_HALT,   4'b0000, 1, 4'b0001, 4'b0000, 4'b0001, 4'b0111, 8'b00111101, 4'b0111, 0);
        vecs[6]  = mk(0, C_HALT,   4'b0000, 1, 4'b0000, 4'b0000, 4'b0111, 4'b0111, 8'b00111101, 4'b0111, 0);
        vecs[7]  = mk(1, C_RESUME, 4'b0111, 1, 4'b0000, 4'b0000, 4'b0111, 4'b0000, 8'b00111101, 4'b0111, 1);
        // CLEAR together with a breakpoint on core 3 (singleton group 1: no self trigger)
        vecs[8]  = mk(1, C_CLEAR,  4'b1111, 1, 4'b1000, 4'b0000, 4'b1000, 4'b1000, 8'b01000000, 4'b1000, 1);
        vecs[9]  = mk(1, C_RESUME, 4'b1000, 1, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 8'b01000000, 4'b1000, 1);
        vecs[10] = mk(1, C_CLEAR,  4'b1111, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'b00000000, 4'b0000, 1);
        // cross-trigger disabled: only core 0 halts
        vecs[11] = mk(0, C_HALT,   4'b0000, 0, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 8'b00000001, 4'b0001, 0);
        vecs[12] = mk(1, C_RESUME, 4'b0001, 0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 8'b00000001, 4'b0001, 1);
        // simultaneous breakpoints on cores 0 and 1
        vecs[13] = mk(0, C_HALT,   4'b0000, 1, 4'b0011, 4'b0000, 4'b0011, 4'b0111, 8'b00110101, 4'b0111, 0);
        vecs[14] = mk(1, C_RESUME, 4'b0111, 1, 4'b0000, 4'b0000, 4'b0111, 4'b0000, 8'b00110101, 4'b0111, 1);
        vecs[15] = mk(1, C_CLEAR,  4'b1111, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'b00000000, 4'b0000, 1);
        // single step on core 1; STEP to running core 0 is ignored but acked
        vecs[16] = mk(1, C_HALT,   4'b0010, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 8'b00001000, 4'b0010, 1);
        vecs[17] = mk(1, C_STEP,   4'b0011, 0, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 8'b00001000, 4'b0010, 1);
        vecs[18] = mk(0, C_HALT,   4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'b00001000, 4'b0010, 0);
        vecs[19] = mk(0, C_HALT,   4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'b00001000, 4'b0010, 0);
        vecs[20] = mk(0, C_HALT,   4'b0000, 0, 4'b0000, 4'b0010, 4'b0000, 4'b0010, 8'b00001000, 4'b0010, 0);
        // retire on running/halted cores has no effect
        vecs[21] = mk(0, C_HALT,   4'b0000, 0, 4'b0000, 4'b1111, 4'b0010, 4'b0010, 8'b00001000, 4'b0010, 0);

        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd = C_HALT; cmd_mask = '0;
        xtrig_en = 1'b0; bp = '0; retire = '0;
        grp_mask[0] = 4'b0111;
        grp_mask[1] = 4'b1000;

        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 22; k++) begin
            apply(vecs[k], k);
        end

        // Put core 0 in HALT and core 2 in STEP, then reset asynchronously mid-cycle.
        apply(mk(1, C_HALT, 4'b0101, 0, 4'b0000, 4'b0000, 4'b0010, 4'b0111, 8'b00101010, 4'b0111, 1), 100);
        apply(mk(1, C_STEP, 4'b0100, 0, 4'b0000, 4'b0000, 4'b0111, 4'b0011, 8'b00101010, 4'b0111, 1), 101);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_mask = '0;
        #2;
        chk("pre_rst_stall", 102, 32'(stall), 32'(4'b0011));
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(posedge clk);
        #1;
        chk_all_zero("held_rst");
        @(negedge clk);
        rst_n = 1'b1;

        apply(mk(1, C_HALT, 4'b1000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 8'b10000000, 4'b1000, 1), 103);
        apply(mk(0, C_HALT, 4'b0000, 0, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 8'b10000000, 4'b1000, 0), 104);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
